dff_bank_reset_seq: RTL
=======================

Name: dff_bank_reset_seq

Overview:
- Reset sequencer placed directly upstream of a flop bank that has asynchronous-reset flops. It drives the bank's reset line and reads the bank outputs back.
- On request, and once automatically after its own reset, it:
  - asserts the bank reset for a programmable number of cycles,
  - waits a settle window,
  - compares the bank Q against the expected post-reset pattern, ignoring masked bits,
  - reports done, a sticky error, and a per-bit mismatch vector.

Parameters:
- WIDTH, 13, number of bank bits observed.
- RST_POL, 1'b0, active level of bank_rst (0 = active-low bank reset).
- RST_VALUE, {WIDTH{1'b0}}, expected bank_q after reset.
- RST_MASK, {WIDTH{1'b1}}, 1 = bit is checked; 0 = don't-care (bank bits with undefined init).
- PULSE_CYC, 4, cycles bank_rst is held active. Must be >= 1.
- SETTLE_CYC, 2, cycles bank_rst is inactive before sampling. May be 0.
- CNT_W, derived localparam = $clog2(max(PULSE_CYC,SETTLE_CYC)+1). Not overridable.

Ports:
- C  input  1  clock; all state updates on rising edge.
- R  input  1  synchronous, active-low reset.
- req  input  1  start a reset/check sequence; sampled only in IDLE.
- bank_rst  output  1  registered reset to the flop bank, level per RST_POL.
- bank_q  input  WIDTH  flop bank outputs, same clock domain.
- busy  output  1  high from ASSERT through CHECK.
- done  output  1  one-cycle pulse when a check result is published.
- err  output  1  high if the last check had any masked mismatch; held until the next result.
- mismatch  output  WIDTH  (bank_q ^ RST_VALUE) & RST_MASK, captured at CHECK; held.

Behaviour:
- States: IDLE, ASSERT, SETTLE, CHECK. One counter of width CNT_W.
- Reset (R low at an edge):
  - state=ASSERT, cnt=0.
  - bank_rst=RST_POL (active), busy=1, done=0, err=0, mismatch=0.
  - While R stays low, bank_rst stays active.
- Power-on check: after R rises, a full sequence runs automatically with no req needed.
- IDLE:
  - bank_rst=~RST_POL, busy=0.
  - req=1 -> ASSERT next cycle, cnt=0.
  - req=0 -> stay in IDLE.
- ASSERT:
  - bank_rst=RST_POL, cnt increments.
  - After PULSE_CYC cycles in ASSERT: go to SETTLE (or CHECK if SETTLE_CYC=0), cnt=0.
- SETTLE:
  - bank_rst=~RST_POL.
  - After SETTLE_CYC cycles: go to CHECK.
- CHECK:
  - Lasts exactly one cycle; bank_q is sampled at its closing edge.
  - Next cycle: mismatch updated, err=|mismatch, done=1 for one cycle, state=IDLE.
- Timing, with req sampled at edge 0:
  - bank_rst active in cycles 1..PULSE_CYC.
  - Settle in cycles PULSE_CYC+1..PULSE_CYC+SETTLE_CYC.
  - CHECK in cycle PULSE_CYC+SETTLE_CYC+1.
  - done visible in cycle PULSE_CYC+SETTLE_CYC+2.
- req while busy=1: ignored, not queued.
- req high in the same cycle as done: accepted (state is already IDLE). Results stay held until the new CHECK completes.
- err and mismatch are not cleared by req; they change only at a CHECK publish or at R.
- R low mid-sequence: the sequence restarts from ASSERT with cnt=0. Any pending result is discarded and done is not pulsed.
- bank_rst is glitch-free: driven directly from a flop, never from combinational state decode.
- Masked bits never contribute to err, whatever bank_q holds (including X in simulation).

Decomposition:
- Shared package `dff_seq_pkg`:
  - state enum (IDLE/ASSERT/SETTLE/CHECK),
  - a function computing CNT_W,
  - constant defaults for PULSE_CYC and SETTLE_CYC.
- One natural sub-module: `dff_bank_checker`.
  - Registered masked compare.
  - Inputs: sample strobe, bank_q, RST_VALUE, RST_MASK.
  - Outputs: mismatch, err, done.
- The FSM/counter stays in the top module.

Test Plan:
- Defaults (WIDTH=13, P=4, S=2, RST_POL=0). Release R; bank model resets to 0.
  -> bank_rst=0 in cycles 1..4 after release, then 1; done in cycle 8; err=0; mismatch=13'h0000.
- Idle, then pulse req=1 for one cycle. Bank model forces Q[3]=1 after reset.
  -> bank_rst low for exactly 4 cycles; done 8 cycles after req; err=1; mismatch=13'h0008.
- Same as the previous case but RST_MASK=13'h1FF7 (bit 3 masked).
  -> err=0, mismatch=13'h0000.
- Hold req=1 continuously.
  -> back-to-back sequences, each with done spaced 8 cycles apart. Extra req during busy is not counted; bank_rst pulse width stays 4.
- Assert R low at cycle 2 of SETTLE.
  -> bank_rst goes active the next cycle; no done pulse. After R rises, a full 4+2 sequence runs; err and mismatch are cleared to 0 until that result is published.
- SETTLE_CYC=0, RST_POL=1.
  -> bank_rst high for 4 cycles; CHECK immediately follows; done 6 cycles after req.

Source files
------------

// File: rtl/dff_seq_pkg.sv
// ---------------------------------------------------------------------------
// dff_seq_pkg
// Shared definitions for the flop-bank reset sequencer:
//   - seq_state_e    : sequencer states (IDLE/ASSERT/SETTLE/CHECK)
//   - DEF_PULSE_CYC  : default number of cycles the bank reset is held active
//   - DEF_SETTLE_CYC : default number of quiet cycles before sampling
//   - calc_cnt_w()   : width of the single phase counter
// No ports (package).
// ---------------------------------------------------------------------------
package dff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } seq_state_e;

  localparam int DEF_PULSE_CYC  = 4;
  localparam int DEF_SETTLE_CYC = 2;

  // The counter must hold values up to max(pulse, settle) - 1; sizing for
  // max+1 keeps a SETTLE_CYC of 0 or a pulse of 1 from producing a zero width.
  function automatic int calc_cnt_w(input int pulse_cyc, input int settle_cyc);
    int m;
    m = (pulse_cyc > settle_cyc) ? pulse_cyc : settle_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dff_bank_checker.sv
// ---------------------------------------------------------------------------
// dff_bank_checker
// Registered masked compare of the flop bank against its post-reset value.
// On a sample strobe the masked difference is captured, the error flag is
// derived from it and a one-cycle done pulse is raised. Results are held
// until the next strobe or until the synchronous reset.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (clears results, no done)
//   sample     in   capture bank_q at this rising edge
//   bank_q     in   [WIDTH] flop bank outputs
//   rst_value  in   [WIDTH] expected post-reset bank value
//   rst_mask   in   [WIDTH] 1 = bit is checked, 0 = don't-care
//   mismatch   out  [WIDTH] held masked difference
//   err        out  held OR-reduction of mismatch
//   done       out  one-cycle pulse when a result is published
// ---------------------------------------------------------------------------
module dff_bank_checker
  import dff_seq_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [WIDTH-1:0] bank_q,
  input  logic [WIDTH-1:0] rst_value,
  input  logic [WIDTH-1:0] rst_mask,
  output logic [WIDTH-1:0] mismatch,
  output logic             err,
  output logic             done
);

  logic [WIDTH-1:0] mismatch_d, mismatch_q;
  logic             err_d, err_q;
  logic             done_d, done_q;

  // Next result: capture on strobe, otherwise hold; done only on strobe.
  always_comb begin
    mismatch_d = mismatch_q;
    err_d      = err_q;
    done_d     = 1'b0;
    if (sample) begin
      // AND with the mask last so an X on a masked bit resolves to 0.
      mismatch_d = (bank_q ^ rst_value) & rst_mask;
      err_d      = |mismatch_d;
      done_d     = 1'b1;
    end else begin
      mismatch_d = mismatch_q;
      err_d      = err_q;
      done_d     = 1'b0;
    end
  end

  // Result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= {WIDTH{1'b0}};
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign mismatch = mismatch_q;
  assign err      = err_q;
  assign done     = done_q;

endmodule

// File: rtl/dff_bank_reset_seq.sv
// ---------------------------------------------------------------------------
// dff_bank_reset_seq
// Reset sequencer for a flop bank built from asynchronous-reset flops.
// After its own reset, and on every accepted request, it pulses the bank
// reset for PULSE_CYC cycles, waits SETTLE_CYC cycles, samples the bank for
// one CHECK cycle and publishes a masked compare result.
// Ports:
//   C         in   clock, rising edge
//   R         in   synchronous active-low reset; restarts the sequence
//   req       in   start a sequence (only honoured in IDLE)
//   bank_rst  out  registered bank reset, active level RST_POL
//   bank_q    in   [WIDTH] bank outputs, same clock domain
//   busy      out  high from ASSERT through CHECK
//   done      out  one-cycle pulse when a check result is published
//   err       out  last published result had a masked mismatch (held)
//   mismatch  out  [WIDTH] last published masked difference (held)
// ---------------------------------------------------------------------------
module dff_bank_reset_seq
  import dff_seq_pkg::*;
#(
  parameter int               WIDTH      = 13,
  parameter logic             RST_POL    = 1'b0,
  parameter logic [WIDTH-1:0] RST_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RST_MASK   = {WIDTH{1'b1}},
  parameter int               PULSE_CYC  = DEF_PULSE_CYC,
  parameter int               SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             C,
  input  logic             R,
  input  logic             req,
  output logic             bank_rst,
  input  logic [WIDTH-1:0] bank_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  localparam int CNT_W = calc_cnt_w(PULSE_CYC, SETTLE_CYC);

  // Terminal counts; the counter runs 0..N-1 inside a phase.
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seq_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             bank_rst_d, bank_rst_q;
  logic             busy_d, busy_q;
  logic             sample_s;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ASSERT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = (SETTLE_CYC == 0) ? CHECK : SETTLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ASSERT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = SETTLE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Decoded from the next state so the flop output lines up with the state
    // it belongs to while bank_rst itself never comes from combinational logic.
    bank_rst_d = (state_d == ASSERT) ? RST_POL : ~RST_POL;
    busy_d     = (state_d != IDLE);
  end

  // bank_q is sampled at the closing edge of the single CHECK cycle.
  assign sample_s = (state_q == CHECK);

  // Sequencer state; reset restarts straight into ASSERT with the bank held.
  always_ff @(posedge C) begin
    if (!R) begin
      state_q    <= ASSERT;
      cnt_q      <= CNT_ZERO;
      bank_rst_q <= RST_POL;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_rst_q <= bank_rst_d;
      busy_q     <= busy_d;
    end
  end

  dff_bank_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk       (C),
    .rst_n     (R),
    .sample    (sample_s),
    .bank_q    (bank_q),
    .rst_value (RST_VALUE),
    .rst_mask  (RST_MASK),
    .mismatch  (mismatch),
    .err       (err),
    .done      (done)
  );

  assign bank_rst = bank_rst_q;
  assign busy     = busy_q;

endmodule
